// File: rtl/sw_memory_fpga.sv
// ---------------------------------------------------------------------------------------------
// sw_memory_fpga
//   Board-level scratch RAM for FPGA bring-up of the CPU memory path. The slide switches supply
//   both the word address and the write data; two push-buttons decide which one is captured.
//
//   Ports
//     clk        system clock, all logic on the rising edge
//     rst        synchronous, active-high reset
//     SW         switches: address source on BTN_addr, data source on BTN_write
//     BTN_addr   address-load button, active-high, asynchronous to clk
//     BTN_write  write button, active-high, asynchronous to clk
//     out        registered read data, mem[addr_q]
//
//   Each button is sampled once, optionally debounced, then edge-detected so that one press
//   produces exactly one single-cycle pulse however long it is held. The RAM is read-first with
//   a registered read port, so it maps onto a block RAM. RAM contents are not touched by reset.
// ---------------------------------------------------------------------------------------------
module sw_memory_fpga #(
  parameter int unsigned ADDR_W          = 12,
  parameter int unsigned DATA_W          = 16,
  parameter int unsigned DEBOUNCE_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] SW,
  input  logic              BTN_addr,
  input  logic              BTN_write,
  output logic [DATA_W-1:0] out
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  // Bit 0 is the address button, bit 1 the write button.
  logic [1:0] btn_raw;
  logic [1:0] btn_s;
  logic [1:0] btn_clean;
  logic [1:0] btn_dly;
  logic [1:0] btn_hold;
  logic [1:0] btn_pulse;

  logic              addr_pulse;
  logic              wr_pulse;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] mem [Depth];

  assign btn_raw = {BTN_write, BTN_addr};

  // ------------------------------------------------------------------------------------------
  // Button conditioning
  // ------------------------------------------------------------------------------------------
  // btn_hold remembers a button that was down while reset was asserted. It masks the edge that
  // would otherwise appear when reset releases under a held button, and clears as soon as the
  // button is seen released, re-arming it for the next genuine press.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_s    <= '0;
      btn_dly  <= btn_clean;
      btn_hold <= btn_raw;
    end else begin
      btn_s    <= btn_raw;
      btn_dly  <= btn_clean;
      btn_hold <= btn_hold & btn_raw;
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_btn
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign btn_clean[i] = btn_s[i];
    end else begin : g_debounce
      localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

      logic [CntW-1:0] cnt_q;

      // Saturating run-length of consecutive high samples; any low sample restarts it.
      always_ff @(posedge clk) begin
        if (rst || !btn_s[i]) begin
          cnt_q <= '0;
        end else if (cnt_q != CntMax) begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end

      // Gated with btn_s so the clean level drops in the same cycle the sample drops.
      assign btn_clean[i] = btn_s[i] && (cnt_q == CntMax);
    end
  end

  assign btn_pulse  = btn_clean & ~btn_dly & ~btn_hold;
  assign addr_pulse = btn_pulse[0];
  assign wr_pulse   = btn_pulse[1];

  // ------------------------------------------------------------------------------------------
  // Address register
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (addr_pulse) begin
      addr_q <= SW[ADDR_W-1:0];
    end
  end

  // ------------------------------------------------------------------------------------------
  // RAM: write uses addr_q as it stood before the edge, so a simultaneous address load and
  // write stores to the old address. No reset on the array keeps it block-RAM inferable.
  // ------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_pulse && !rst) begin
      mem[addr_q] <= SW;
    end
  end

  // Read-first registered read port; reset only clears the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= '0;
    end else begin
      out <= mem[addr_q];
    end
  end

endmodule

// File: tb/tb_sw_memory_fpga.sv
// ---------------------------------------------------------------------------------------------
// tb_sw_memory_fpga
//   Self-checking bench for sw_memory_fpga. Stimulus is issued as whole operations (address
//   load, write, both, switch change); a reference model of the RAM and address register
//   predicts the word on out and pushes it into a queue. A separate monitor pops and compares.
//   A second instance with DEBOUNCE_CYCLES=4 checks that short glitches are ignored.
// ---------------------------------------------------------------------------------------------
module tb_sw_memory_fpga;

  logic        clk;
  logic        rst;
  logic [15:0] SW;
  logic        BTN_addr;
  logic        BTN_write;
  logic [15:0] out;

  logic        db_btn_addr;
  logic        db_btn_write;
  logic [15:0] db_out;

  int checks;
  int errors;

  // Reference model: sparse RAM of words written so far, plus the current address.
  logic [15:0] mem_m [int];
  logic [11:0] addr_m;

  // Scoreboard queues.
  logic [15:0] exp_q [$];
  string       name_q [$];
  logic [15:0] mon_exp;
  string       mon_name;

  sw_memory_fpga #(
    .ADDR_W          (12),
    .DATA_W          (16),
    .DEBOUNCE_CYCLES (0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .SW        (SW),
    .BTN_addr  (BTN_addr),
    .BTN_write (BTN_write),
    .out       (out)
  );

  sw_memory_fpga #(
    .ADDR_W          (12),
    .DATA_W          (16),
    .DEBOUNCE_CYCLES (4)
  ) dut_db (
    .clk       (clk),
    .rst       (rst),
    .SW        (SW),
    .BTN_addr  (db_btn_addr),
    .BTN_write (db_btn_write),
    .out       (db_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=500000", $time);
    $fatal(1);
  end

  // Monitor: every expectation pushed at a falling edge is checked 2 time units later, well
  // away from the rising edge where out changes.
  always begin
    @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      checks++;
      if (out !== mon_exp) begin
        errors++;
        $display("FAIL %s: out=%h expected=%h", mon_name, out, mon_exp);
      end
    end
  end

  task automatic expect_out(input logic [15:0] v, input string nm);
    exp_q.push_back(v);
    name_q.push_back(nm);
  endtask

  // One button press of one cycle, then let the result settle; update the model and predict.
  task automatic do_op(input bit a, input bit w, input logic [15:0] sw, input string nm);
    @(negedge clk);
    SW        = sw;
    BTN_addr  = a;
    BTN_write = w;
    @(negedge clk);
    BTN_addr  = 1'b0;
    BTN_write = 1'b0;
    repeat (3) @(negedge clk);
    if (w) mem_m[int'(addr_m)] = sw;
    if (a) addr_m = sw[11:0];
    if (mem_m.exists(int'(addr_m))) expect_out(mem_m[int'(addr_m)], nm);
  endtask

  task automatic db_check(input logic [15:0] v, input string nm);
    @(negedge clk);
    #2;
    checks++;
    if (db_out !== v) begin
      errors++;
      $display("FAIL %s: db_out=%h expected=%h", nm, db_out, v);
    end
  endtask

  logic [11:0] pool [4];

  initial begin
    checks       = 0;
    errors       = 0;
    addr_m       = '0;
    rst          = 1'b1;
    SW           = '0;
    BTN_addr     = 1'b0;
    BTN_write    = 1'b0;
    db_btn_addr  = 1'b0;
    db_btn_write = 1'b0;

    // Reset, then write address 0 to confirm addr_q cleared.
    repeat (3) @(negedge clk);
    expect_out(16'h0000, "reset_out");
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 1'b1, 16'h0F0F, "write_addr0_after_reset");

    // Button activity during reset, write button held across release: no action at all.
    @(negedge clk);
    rst       = 1'b1;
    SW        = 16'hDEAD;
    BTN_addr  = 1'b1;
    BTN_write = 1'b1;
    @(negedge clk);
    BTN_addr  = 1'b0;
    @(negedge clk);
    expect_out(16'h0000, "out_during_reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    BTN_write = 1'b0;
    repeat (3) @(negedge clk);
    addr_m = '0;
    expect_out(mem_m[0], "no_action_from_reset_press");

    // Load / write / read, and switches changing afterwards.
    do_op(1'b1, 1'b0, 16'h0005, "load_5");
    do_op(1'b0, 1'b1, 16'h3039, "write_3039");
    do_op(1'b0, 1'b0, 16'hFFFF, "sw_change_no_effect");

    // Second location, then back to the first.
    do_op(1'b1, 1'b0, 16'h07D9, "load_7d9");
    do_op(1'b0, 1'b1, 16'hABCD, "write_abcd");
    do_op(1'b1, 1'b0, 16'h0005, "reload_5");

    // Upper switch bits are ignored on address load.
    do_op(1'b1, 1'b0, 16'h07D9, "load_7d9_again");
    do_op(1'b1, 1'b0, 16'hF005, "load_f005_wraps");

    // Held write button with data changing mid-hold: exactly one write of the first value.
    do_op(1'b1, 1'b0, 16'h0100, "load_100");
    @(negedge clk);
    SW        = 16'h1111;
    BTN_write = 1'b1;
    repeat (10) @(negedge clk);
    SW = 16'h2222;
    repeat (10) @(negedge clk);
    BTN_write = 1'b0;
    repeat (3) @(negedge clk);
    mem_m[int'(addr_m)] = 16'h1111;
    expect_out(16'h1111, "held_write_once");

    // Simultaneous press: write lands at the old address, address moves to the new one.
    do_op(1'b1, 1'b0, 16'h0009, "load_9");
    do_op(1'b0, 1'b1, 16'h9999, "write_9999");
    do_op(1'b1, 1'b0, 16'h0005, "load_5_before_both");
    do_op(1'b1, 1'b1, 16'h0009, "both_buttons");
    do_op(1'b1, 1'b0, 16'h0005, "read_back_5_after_both");

    // Randomised operations over a small address pool so locations get revisited.
    for (int i = 0; i < 4; i++) pool[i] = 12'($urandom);
    for (int i = 0; i < 40; i++) begin
      int          op;
      logic [15:0] d;
      logic [11:0] ad;
      op = $urandom_range(0, 3);
      d  = 16'($urandom);
      ad = pool[$urandom_range(0, 3)];
      case (op)
        0:       do_op(1'b1, 1'b0, {d[15:12], ad}, "rand_load");
        1:       do_op(1'b0, 1'b1, d, "rand_write");
        2:       do_op(1'b1, 1'b1, {d[15:12], ad}, "rand_both");
        default: do_op(1'b0, 1'b0, d, "rand_sw_change");
      endcase
    end

    // Debounced instance: a long press writes, 2-cycle glitches do nothing.
    @(negedge clk);
    SW           = 16'hAAAA;
    db_btn_write = 1'b1;
    repeat (10) @(negedge clk);
    db_btn_write = 1'b0;
    repeat (3) @(negedge clk);
    db_check(16'hAAAA, "db_long_press_write");

    SW           = 16'h5555;
    db_btn_write = 1'b1;
    repeat (2) @(negedge clk);
    db_btn_write = 1'b0;
    repeat (8) @(negedge clk);
    db_check(16'hAAAA, "db_write_glitch_ignored");

    SW          = 16'h0007;
    db_btn_addr = 1'b1;
    repeat (2) @(negedge clk);
    db_btn_addr = 1'b0;
    repeat (8) @(negedge clk);
    db_check(16'hAAAA, "db_addr_glitch_ignored");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: pending=%0d expected=0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
